seq_timing_unit: RTL and testbench
==================================

Name: seq_timing_unit

Overview:
- Parametrised successor to the CPU system's hard-wired T[11:0] timing input and fixed 6-to-64 opcode decoder.
- Generates the one-hot timing-step vector T and the one-hot opcode-decode vector D for the control logic.
- Drives the two-step instruction-fetch controls IR_Write and IR_LH.
- Adds stall, early instruction termination, illegal-opcode abort, step-overrun detection and a retired-instruction counter.

Parameters:
NUM_STEPS, 12, number of timing steps T0..T(NUM_STEPS-1); legal range 3..32
IR_W, 16, instruction register width
OPCODE_W, 6, opcode field width; the opcode is IRIn[IR_W-1 -: OPCODE_W]
NUM_OPCODES, 36, opcodes 0..NUM_OPCODES-1 are legal; legal range 1..2^OPCODE_W
CNT_W, 16, width of the retired-instruction counter

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Enable  in  1  1 = advance the sequence; 0 = stall and hold all state
SeqClear  in  1  current instruction is complete; return to T0
OverrunClr  in  1  clears the sticky Overrun flag
IRIn  in  IR_W  current instruction register contents
T  out  NUM_STEPS  one-hot timing step
D  out  2^OPCODE_W  one-hot opcode decode; all zeros during fetch or on an illegal opcode
IR_Write  out  1  instruction register load enable
IR_LH  out  1  instruction register half select: 0 = low half, 1 = high half
Illegal  out  1  one-cycle pulse in T2 when the opcode is illegal
Overrun  out  1  sticky flag: the sequence wrapped without a SeqClear
InstrCnt  out  CNT_W  number of retired instructions; wraps modulo 2^CNT_W

Behaviour:
- State: step register StepCnt, width $clog2(NUM_STEPS); Overrun flag; InstrCnt register.
- T = 1 << StepCnt.
- Reset low, at any time including mid-instruction:
  - StepCnt = 0, so T = 1.
  - Overrun = 0 and InstrCnt = 0.
  - Outputs follow from these values: IR_Write = Enable, IR_LH = 0, D = 0, Illegal = 0.
- Fetch covers StepCnt 0 and 1:
  - IR_Write = Enable && (StepCnt < 2).
  - IR_LH = StepCnt[0] during fetch, 0 otherwise.
- Opcode field: op = IRIn[IR_W-1 -: OPCODE_W].
- Decode:
  - D = (1 << op) when StepCnt >= 2 and op < NUM_OPCODES; otherwise D = 0.
  - D is combinational and follows IRIn.
- Illegal = Enable && (StepCnt == 2) && (op >= NUM_OPCODES).
- Next-step priority at each rising edge:
  1. Enable = 0: hold StepCnt, Overrun and InstrCnt. SeqClear is ignored.
  2. Illegal: StepCnt <= 0. InstrCnt is not incremented.
  3. SeqClear && StepCnt >= 2: StepCnt <= 0; InstrCnt <= InstrCnt + 1.
  4. SeqClear during fetch (StepCnt 0 or 1) is ignored; the sequence advances normally.
  5. StepCnt == NUM_STEPS-1: StepCnt <= 0; Overrun <= 1.
  6. Otherwise: StepCnt <= StepCnt + 1.
- SeqClear in the last step takes case 3: no Overrun, InstrCnt increments.
- Overrun:
  - Cleared when OverrunClr = 1, regardless of Enable.
  - If OverrunClr coincides with a new overrun event, the set wins: Overrun stays 1.
- All outputs except T's register and the counters are combinational from StepCnt, IRIn and Enable.
- No latency beyond one clock per step.
- Outputs carry no X after reset; IRIn containing X affects only D and Illegal.

Decomposition:
- Package seq_pkg holds:
  - FETCH_STEPS = 2
  - DECODE_STEP = 2
  - a function clog2_steps for the StepCnt width
- Sub-module onehot_decoder:
  - parameters IN_W and OUT_W; output bits at or above OUT_W are 0
  - instantiated twice: for T (IN_W = step width, OUT_W = NUM_STEPS) and for D (IN_W = OPCODE_W, OUT_W = 2^OPCODE_W)
  - the legal-opcode gating of D is applied in seq_timing_unit

Test Plan:
- Reset release with Enable = 1 and IRIn = 16'h0C00 (op 3):
  - T steps 001 -> 002 -> 004.
  - IR_Write = 1 and IR_LH = 0 in T0; IR_Write = 1 and IR_LH = 1 in T1.
  - In T2: D = 64'h8.
  - SeqClear in T3 -> T0 next cycle and InstrCnt = 1.
- IRIn = 16'hFC00 (op 63):
  - In T2: Illegal = 1 and D = 0.
  - Next cycle: T = 1 and InstrCnt unchanged.
- Enable = 0 for 3 cycles during T4:
  - T stays 0x010; IR_Write = 0; SeqClear is ignored.
  - Enable = 1 -> T = 0x020.
- No SeqClear with NUM_STEPS = 12:
  - After T11 (0x800): T = 0x001 and Overrun = 1.
  - OverrunClr pulse -> Overrun = 0.
  - SeqClear in T11 -> T = 1, Overrun remains 0.
- SeqClear asserted in T1 -> ignored; T = 0x004 next cycle.
- Reset asserted asynchronously mid-T6 with InstrCnt = 5:
  - Immediately: T = 1, InstrCnt = 0, Overrun = 0, D = 0.
  - Repeat the whole test plan with NUM_STEPS = 5 and OPCODE_W = 4.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants, step-action encoding and width helper for the timing sequencer.
package seq_pkg;

  localparam int unsigned FETCH_STEPS = 2;
  localparam int unsigned DECODE_STEP = 2;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_ABORT,
    ACT_RETIRE,
    ACT_WRAP,
    ACT_ADV
  } step_act_e;

  // Step counter width; never below one bit.
  function automatic int unsigned clog2_steps(input int unsigned n);
    if (n < 2) return 1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/seq_timing_unit_if.sv
// Control-side bundle of the timing sequencer: stall/clear inputs, IR contents, step and decode outputs.
interface seq_timing_unit_if #(
  parameter int unsigned NUM_STEPS = 12,
  parameter int unsigned IR_W      = 16,
  parameter int unsigned OPCODE_W  = 6,
  parameter int unsigned CNT_W     = 16
);
  logic                     Enable;
  logic                     SeqClear;
  logic                     OverrunClr;
  logic [IR_W-1:0]          IRIn;
  logic [NUM_STEPS-1:0]     T;
  logic [2**OPCODE_W-1:0]   D;
  logic                     IR_Write;
  logic                     IR_LH;
  logic                     Illegal;
  logic                     Overrun;
  logic [CNT_W-1:0]         InstrCnt;

  modport master (
    output Enable, SeqClear, OverrunClr, IRIn,
    input  T, D, IR_Write, IR_LH, Illegal, Overrun, InstrCnt
  );

  modport slave (
    input  Enable, SeqClear, OverrunClr, IRIn,
    output T, D, IR_Write, IR_LH, Illegal, Overrun, InstrCnt
  );
endinterface

// File: rtl/onehot_decoder.sv
// Binary to one-hot decoder; select values at or above OUT_W give all zeros.
module onehot_decoder #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 16
) (
  input  logic [IN_W-1:0]  sel,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      onehot[i] = (i == 32'(sel));
    end
  end

endmodule

// File: rtl/seq_timing_unit.sv
// Instruction timing sequencer: one-hot step/opcode decode, two-step IR fetch, stall,
// early termination, illegal-opcode abort, sticky overrun flag and retired-instruction count.
module seq_timing_unit
  import seq_pkg::*;
#(
  parameter int unsigned NUM_STEPS   = 12,
  parameter int unsigned IR_W        = 16,
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned NUM_OPCODES = 36,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  seq_timing_unit_if.slave  bus
);

  localparam int unsigned STEP_W = clog2_steps(NUM_STEPS);
  localparam int unsigned D_W    = 2**OPCODE_W;

  logic [STEP_W-1:0]    step_cnt, step_nxt;
  logic                 overrun_q, overrun_nxt;
  logic [CNT_W-1:0]     instr_cnt, instr_nxt;
  logic [OPCODE_W-1:0]  op;
  logic                 fetch, op_legal, illegal;
  logic [NUM_STEPS-1:0] t_vec;
  logic [D_W-1:0]       d_raw;
  logic                 unused_ir_bits;
  step_act_e            act;

  assign op             = bus.IRIn[IR_W-1 -: OPCODE_W];
  assign unused_ir_bits = ^bus.IRIn;
  assign fetch          = step_cnt < STEP_W'(FETCH_STEPS);
  assign op_legal       = 32'(op) < NUM_OPCODES;
  assign illegal        = bus.Enable && (step_cnt == STEP_W'(DECODE_STEP)) && !op_legal;

  onehot_decoder #(.IN_W(STEP_W), .OUT_W(NUM_STEPS)) u_step_dec (
    .sel    (step_cnt),
    .onehot (t_vec)
  );

  onehot_decoder #(.IN_W(OPCODE_W), .OUT_W(D_W)) u_op_dec (
    .sel    (op),
    .onehot (d_raw)
  );

  // Step, overrun flag and instruction counter registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      step_cnt  <= '0;
      overrun_q <= 1'b0;
      instr_cnt <= '0;
    end else begin
      step_cnt  <= step_nxt;
      overrun_q <= overrun_nxt;
      instr_cnt <= instr_nxt;
    end
  end

  // Next-step priority: stall, abort, retire, wrap, advance.
  always_comb begin
    act         = ACT_ADV;
    step_nxt    = step_cnt;
    instr_nxt   = instr_cnt;
    overrun_nxt = overrun_q && !bus.OverrunClr;

    if (!bus.Enable)                     act = ACT_HOLD;
    else if (illegal)                    act = ACT_ABORT;
    else if (bus.SeqClear && !fetch)     act = ACT_RETIRE;
    else if (step_cnt == STEP_W'(NUM_STEPS-1)) act = ACT_WRAP;

    unique case (act)
      ACT_ABORT:  step_nxt = '0;
      ACT_RETIRE: begin
        step_nxt  = '0;
        instr_nxt = instr_cnt + CNT_W'(1);
      end
      ACT_WRAP: begin
        step_nxt    = '0;
        overrun_nxt = 1'b1;
      end
      ACT_ADV:    step_nxt = step_cnt + STEP_W'(1);
      default:    ;
    endcase
  end

  assign bus.T        = t_vec;
  assign bus.D        = (!fetch && op_legal) ? d_raw : '0;
  assign bus.IR_Write = bus.Enable && fetch;
  assign bus.IR_LH    = fetch && step_cnt[0];
  assign bus.Illegal  = illegal;
  assign bus.Overrun  = overrun_q;
  assign bus.InstrCnt = instr_cnt;

endmodule

// File: tb/tb_seq_timing_unit.sv
// Directed vector bench for seq_timing_unit in a 12-step/6-bit-opcode and a 5-step/4-bit-opcode build.
module tb_seq_timing_unit;

  typedef struct {
    bit          rst;
    bit          en;
    bit          sc;
    bit          oc;
    logic [15:0] ir;
    logic [63:0] t;
    logic [63:0] d;
    bit          irw;
    bit          lh;
    bit          ill;
    bit          ovr;
    logic [63:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   tests = 0;
  int   fails = 0;
  vec_t qa[$];
  vec_t qb[$];

  always #5 clk = ~clk;

  seq_timing_unit_if #(.NUM_STEPS(12), .IR_W(16), .OPCODE_W(6), .CNT_W(16)) bus_a ();
  seq_timing_unit_if #(.NUM_STEPS(5),  .IR_W(16), .OPCODE_W(4), .CNT_W(16)) bus_b ();

  seq_timing_unit #(.NUM_STEPS(12), .IR_W(16), .OPCODE_W(6), .NUM_OPCODES(36), .CNT_W(16)) dut_a (
    .Clock (clk),
    .Reset (rst_a),
    .bus   (bus_a)
  );

  seq_timing_unit #(.NUM_STEPS(5), .IR_W(16), .OPCODE_W(4), .NUM_OPCODES(10), .CNT_W(16)) dut_b (
    .Clock (clk),
    .Reset (rst_b),
    .bus   (bus_b)
  );

  function automatic vec_t mk(input int rst, input int en, input int sc, input int oc,
                              input logic [15:0] ir, input longint t, input longint d,
                              input int irw, input int lh, input int ill, input int ovr,
                              input int cnt);
    vec_t v;
    v.rst = (rst != 0); v.en = (en != 0); v.sc = (sc != 0); v.oc = (oc != 0);
    v.ir  = ir;
    v.t   = 64'(t);
    v.d   = 64'(d);
    v.irw = (irw != 0); v.lh = (lh != 0); v.ill = (ill != 0); v.ovr = (ovr != 0);
    v.cnt = 64'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector after the falling edge, then check outputs before the next rising edge.
  task automatic run_vec(input bit b, input int idx, input vec_t v);
    logic [63:0] t, d, cnt;
    logic        irw, lh, ill, ovr;
    string       tag;
    @(negedge clk);
    if (b) begin
      rst_b = v.rst; bus_b.Enable = v.en; bus_b.SeqClear = v.sc;
      bus_b.OverrunClr = v.oc; bus_b.IRIn = v.ir;
    end else begin
      rst_a = v.rst; bus_a.Enable = v.en; bus_a.SeqClear = v.sc;
      bus_a.OverrunClr = v.oc; bus_a.IRIn = v.ir;
    end
    #1;
    if (b) begin
      t = 64'(bus_b.T); d = 64'(bus_b.D); cnt = 64'(bus_b.InstrCnt);
      irw = bus_b.IR_Write; lh = bus_b.IR_LH; ill = bus_b.Illegal; ovr = bus_b.Overrun;
    end else begin
      t = 64'(bus_a.T); d = 64'(bus_a.D); cnt = 64'(bus_a.InstrCnt);
      irw = bus_a.IR_Write; lh = bus_a.IR_LH; ill = bus_a.Illegal; ovr = bus_a.Overrun;
    end
    tag = $sformatf("%s[%0d]", b ? "B" : "A", idx);
    chk({tag, ".T"},        t,          v.t);
    chk({tag, ".D"},        d,          v.d);
    chk({tag, ".IR_Write"}, 64'(irw),   64'(v.irw));
    chk({tag, ".IR_LH"},    64'(lh),    64'(v.lh));
    chk({tag, ".Illegal"},  64'(ill),   64'(v.ill));
    chk({tag, ".Overrun"},  64'(ovr),   64'(v.ovr));
    chk({tag, ".InstrCnt"}, cnt,        v.cnt);
  endtask

  localparam logic [15:0] OP3  = 16'h0C00;
  localparam logic [15:0] OP35 = 16'h8C00;
  localparam logic [15:0] OP36 = 16'h9000;
  localparam logic [15:0] OP63 = 16'hFC00;
  localparam logic [15:0] B3   = 16'h3000;
  localparam logic [15:0] B9   = 16'h9000;
  localparam logic [15:0] B10  = 16'hA000;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    bus_a.Enable = 1'b0; bus_a.SeqClear = 1'b0; bus_a.OverrunClr = 1'b0; bus_a.IRIn = '0;
    bus_b.Enable = 1'b0; bus_b.SeqClear = 1'b0; bus_b.OverrunClr = 1'b0; bus_b.IRIn = '0;

    // 12-step build: fetch, decode, retire, illegal abort, fetch-clear ignored.
    qa.push_back(mk(0,1,0,0,OP3,  1,0,1,0,0,0,0));
    qa.push_back(mk(1,1,0,0,OP3,  1,0,1,0,0,0,0));
    qa.push_back(mk(1,1,0,0,OP3,  2,0,1,1,0,0,0));
    qa.push_back(mk(1,1,0,0,OP3,  4,8,0,0,0,0,0));
    qa.push_back(mk(1,1,1,0,OP3,  8,8,0,0,0,0,0));
    qa.push_back(mk(1,1,0,0,OP3,  1,0,1,0,0,0,1));
    qa.push_back(mk(1,1,0,0,OP63, 2,0,1,1,0,0,1));
    qa.push_back(mk(1,1,0,0,OP63, 4,0,0,0,1,0,1));
    qa.push_back(mk(1,1,0,0,OP3,  1,0,1,0,0,0,1));
    qa.push_back(mk(1,1,1,0,OP3,  2,0,1,1,0,0,1));
    qa.push_back(mk(1,1,0,0,OP3,  4,8,0,0,0,0,1));
    qa.push_back(mk(1,1,0,0,OP3,  8,8,0,0,0,0,1));
    // Stall three cycles in T4 with SeqClear held.
    for (int i = 0; i < 3; i++) qa.push_back(mk(1,0,1,0,OP3,16,8,0,0,0,0,1));
    qa.push_back(mk(1,1,0,0,OP3, 16,8,0,0,0,0,1));
    for (int k = 5; k <= 11; k++) qa.push_back(mk(1,1,0,0,OP3,longint'(1) << k,8,0,0,0,0,1));
    // Wrap sets Overrun; pulse OverrunClr in that cycle.
    qa.push_back(mk(1,1,0,1,OP3,  1,0,1,0,0,1,1));
    qa.push_back(mk(1,1,0,0,OP3,  2,0,1,1,0,0,1));
    for (int k = 2; k <= 10; k++) qa.push_back(mk(1,1,0,0,OP3,longint'(1) << k,8,0,0,0,0,1));
    qa.push_back(mk(1,1,1,0,OP3,'h800,8,0,0,0,0,1));
    qa.push_back(mk(1,1,0,0,OP3,  1,0,1,0,0,0,2));
    // First illegal opcode, seen while stalled then enabled.
    qa.push_back(mk(1,1,0,0,OP3,  2,0,1,1,0,0,2));
    qa.push_back(mk(1,0,0,0,OP36, 4,0,0,0,0,0,2));
    qa.push_back(mk(1,1,0,0,OP36, 4,0,0,0,1,0,2));
    qa.push_back(mk(1,1,0,0,OP3,  1,0,1,0,0,0,2));
    for (int c = 3; c <= 5; c++) begin
      qa.push_back(mk(1,1,0,0,(c == 4) ? OP35 : OP3, 2,0,1,1,0,0,c-1));
      qa.push_back(mk(1,1,1,0,(c == 4) ? OP35 : OP3, 4,(c == 4) ? 64'h8_0000_0000 : 8,0,0,0,0,c-1));
      qa.push_back(mk(1,1,0,0,OP3, 1,0,1,0,0,0,c));
    end
    for (int k = 1; k <= 6; k++)
      qa.push_back(mk(1,1,0,0,OP3,longint'(1) << k,(k >= 2) ? 8 : 0,(k < 2) ? 1 : 0,(k == 1) ? 1 : 0,0,0,5));

    // 5-step build: op 9 is the last legal opcode, op 10 the first illegal.
    qb.push_back(mk(0,1,0,0,B3,   1,0,1,0,0,0,0));
    qb.push_back(mk(1,1,0,0,B3,   1,0,1,0,0,0,0));
    qb.push_back(mk(1,1,0,0,B3,   2,0,1,1,0,0,0));
    qb.push_back(mk(1,1,0,0,B3,   4,8,0,0,0,0,0));
    qb.push_back(mk(1,1,1,0,B3,   8,8,0,0,0,0,0));
    qb.push_back(mk(1,1,0,0,B3,   1,0,1,0,0,0,1));
    qb.push_back(mk(1,1,0,0,B10,  2,0,1,1,0,0,1));
    qb.push_back(mk(1,1,0,0,B10,  4,0,0,0,1,0,1));
    qb.push_back(mk(1,1,1,0,B9,   1,0,1,0,0,0,1));
    qb.push_back(mk(1,1,1,0,B9,   2,0,1,1,0,0,1));
    qb.push_back(mk(1,1,0,0,B9,   4,'h200,0,0,0,0,1));
    qb.push_back(mk(1,1,0,0,B9,   8,'h200,0,0,0,0,1));
    for (int i = 0; i < 3; i++) qb.push_back(mk(1,0,1,0,B9,16,'h200,0,0,0,0,1));
    qb.push_back(mk(1,1,0,0,B9,  16,'h200,0,0,0,0,1));
    qb.push_back(mk(1,1,0,1,B9,   1,0,1,0,0,1,1));
    qb.push_back(mk(1,1,0,0,B9,   2,0,1,1,0,0,1));
    qb.push_back(mk(1,1,0,0,B9,   4,'h200,0,0,0,0,1));
    qb.push_back(mk(1,1,0,0,B9,   8,'h200,0,0,0,0,1));
    qb.push_back(mk(1,1,1,0,B9,  16,'h200,0,0,0,0,1));
    qb.push_back(mk(1,1,0,0,B9,   1,0,1,0,0,0,2));
    qb.push_back(mk(1,1,0,0,B9,   2,0,1,1,0,0,2));
    qb.push_back(mk(1,1,0,0,B9,   4,'h200,0,0,0,0,2));
    qb.push_back(mk(1,1,0,0,B9,   8,'h200,0,0,0,0,2));
    // OverrunClr coinciding with a wrap: the set wins; then clear while stalled.
    qb.push_back(mk(1,1,0,1,B9,  16,'h200,0,0,0,0,2));
    qb.push_back(mk(1,0,0,1,B9,   1,0,0,0,0,1,2));
    qb.push_back(mk(1,0,0,0,B9,   1,0,0,0,0,0,2));
    qb.push_back(mk(1,1,0,0,B9,   1,0,1,0,0,0,2));
    qb.push_back(mk(1,1,0,0,B9,   2,0,1,1,0,0,2));
    qb.push_back(mk(1,1,0,0,B9,   4,'h200,0,0,0,0,2));
    qb.push_back(mk(1,1,0,0,B9,   8,'h200,0,0,0,0,2));
    qb.push_back(mk(1,1,0,0,B9,  16,'h200,0,0,0,0,2));
    qb.push_back(mk(1,1,0,0,B9,   1,0,1,0,0,1,2));
    qb.push_back(mk(1,1,0,0,B9,   2,0,1,1,0,1,2));
    qb.push_back(mk(1,1,0,0,B9,   4,'h200,0,0,0,1,2));

    foreach (qa[i]) run_vec(1'b0, i, qa[i]);

    // Asynchronous reset in the middle of T6 with five retired instructions.
    #2 rst_a = 1'b0;
    #1;
    chk("A.async.T",        64'(bus_a.T),        64'h1);
    chk("A.async.InstrCnt", 64'(bus_a.InstrCnt), 64'h0);
    chk("A.async.Overrun",  64'(bus_a.Overrun),  64'h0);
    chk("A.async.D",        64'(bus_a.D),        64'h0);
    chk("A.async.IR_Write", 64'(bus_a.IR_Write), 64'h1);
    @(negedge clk) rst_a = 1'b1;
    @(negedge clk) #1;
    chk("A.release.T",      64'(bus_a.T),        64'h2);

    foreach (qb[i]) run_vec(1'b1, i, qb[i]);

    // Asynchronous reset mid-T2 with Overrun set and two retired instructions.
    #2 rst_b = 1'b0;
    #1;
    chk("B.async.T",        64'(bus_b.T),        64'h1);
    chk("B.async.InstrCnt", 64'(bus_b.InstrCnt), 64'h0);
    chk("B.async.Overrun",  64'(bus_b.Overrun),  64'h0);
    chk("B.async.D",        64'(bus_b.D),        64'h0);
    chk("B.async.Illegal",  64'(bus_b.Illegal),  64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
